// File: rtl/pipe_funnel_shifter_pkg.sv
// Shared op encoding for the shift unit and the ALU decoder that feeds it.
package pipe_funnel_shifter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4,
        OP_FSR = 3'd5
    } op_e;

endpackage

// File: rtl/pipe_funnel_shifter_stage.sv
// One funnel pipeline stage: registers valid/data/k/tag/err and conditionally
// shifts the 2W-bit funnel right by SH when the matching bit of k is set.
module pfs_stage #(
    parameter int W     = 8,
    parameter int TAG_W = 4,
    parameter int SH    = 1,
    localparam int AW   = $clog2(W) + 1,
    localparam int KB   = $clog2(SH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv_i,
    input  logic               vld_i,
    input  logic [2*W-1:0]     data_i,
    input  logic [AW-1:0]      k_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               err_i,
    output logic               vld_o,
    output logic [2*W-1:0]     data_o,
    output logic [AW-1:0]      k_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               err_o
);

    logic             vld_q;
    logic [2*W-1:0]   data_q;
    logic [AW-1:0]    k_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;

    // Load from predecessor whenever the pipe advances; bubbles move too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            k_q    <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else if (adv_i) begin
            vld_q  <= vld_i;
            data_q <= k_i[KB] ? (data_i >> SH) : data_i;
            k_q    <= k_i;
            tag_q  <= tag_i;
            err_q  <= err_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign k_o    = k_q;
    assign tag_o  = tag_q;
    assign err_o  = err_q;

endmodule

// File: rtl/pipe_funnel_shifter.sv
// Pipelined shift unit: every op is folded into a 2W-bit funnel right shift by
// k (0..W), then resolved one shift-amount bit per register stage.
module pipe_funnel_shifter
    import pipe_funnel_shifter_pkg::*;
#(
    parameter int W     = 8,
    parameter int TAG_W = 4,
    localparam int AW   = $clog2(W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [AW-1:0]    in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam logic [AW-1:0] WK = AW'(W);

    // Index 0 is the decode register, AW is the output stage.
    logic [AW:0]                vld_pipe;
    logic [AW:0][2*W-1:0]       data_pipe;
    logic [AW:0][AW-1:0]        k_pipe;
    logic [AW:0][TAG_W-1:0]     tag_pipe;
    logic [AW:0]                err_pipe;

    logic adv;
    assign adv      = out_ready || !vld_pipe[AW];
    assign in_ready = adv;

    logic [AW-1:0]  amt_sat, amt_mod, rol_tmp, k_d;
    logic [2*W-1:0] fun_d;
    logic           err_d;

    // Decode each op into {hi, lo} plus a right-shift amount k in 0..W.
    always_comb begin
        amt_sat = (in_amt > WK) ? WK : in_amt;
        amt_mod = {1'b0, in_amt[AW-2:0]};
        rol_tmp = WK - amt_mod;
        fun_d   = '0;
        k_d     = '0;
        err_d   = 1'b0;
        case (in_op)
            OP_LSL: begin fun_d = {in_a, {W{1'b0}}};     k_d = WK - amt_sat;               end
            OP_LSR: begin fun_d = {{W{1'b0}}, in_a};     k_d = amt_sat;                    end
            OP_ASR: begin fun_d = {{W{in_a[W-1]}}, in_a}; k_d = amt_sat;                   end
            OP_ROL: begin fun_d = {in_a, in_a};          k_d = {1'b0, rol_tmp[AW-2:0]};    end
            OP_ROR: begin fun_d = {in_a, in_a};          k_d = amt_mod;                    end
            OP_FSR: begin fun_d = {in_b, in_a};          k_d = amt_sat;                    end
            default: err_d = 1'b1;
        endcase
    end

    logic             s0_vld_q;
    logic [2*W-1:0]   s0_data_q;
    logic [AW-1:0]    s0_k_q;
    logic [TAG_W-1:0] s0_tag_q;
    logic             s0_err_q;

    // Decode register; in_ready == adv, so accept is simply in_valid here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld_q  <= 1'b0;
            s0_data_q <= '0;
            s0_k_q    <= '0;
            s0_tag_q  <= '0;
            s0_err_q  <= 1'b0;
        end else if (adv) begin
            s0_vld_q  <= in_valid;
            s0_data_q <= fun_d;
            s0_k_q    <= k_d;
            s0_tag_q  <= in_tag;
            s0_err_q  <= err_d;
        end
    end

    assign vld_pipe[0]  = s0_vld_q;
    assign data_pipe[0] = s0_data_q;
    assign k_pipe[0]    = s0_k_q;
    assign tag_pipe[0]  = s0_tag_q;
    assign err_pipe[0]  = s0_err_q;

    for (genvar j = 1; j <= AW; j++) begin : g_stg
        pfs_stage #(.W(W), .TAG_W(TAG_W), .SH(1 << (j-1))) u_stg (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv_i  (adv),
            .vld_i  (vld_pipe[j-1]),
            .data_i (data_pipe[j-1]),
            .k_i    (k_pipe[j-1]),
            .tag_i  (tag_pipe[j-1]),
            .err_i  (err_pipe[j-1]),
            .vld_o  (vld_pipe[j]),
            .data_o (data_pipe[j]),
            .k_o    (k_pipe[j]),
            .tag_o  (tag_pipe[j]),
            .err_o  (err_pipe[j])
        );
    end

    assign out_valid = vld_pipe[AW];
    assign out_data  = data_pipe[AW][W-1:0];
    assign out_tag   = tag_pipe[AW];
    assign out_err   = err_pipe[AW];

    // The final k and the upper funnel half carry no information at the output.
    logic unused_ok;
    assign unused_ok = ^{k_pipe[AW], data_pipe[AW][2*W-1:W]};

endmodule
